// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// The optional ARB_STATS_EN build adds the per-requester beat counters.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  // Index that follows idx in a ring of nreq requesters.
  function automatic int rr_next(input int idx, input int nreq);
    return (idx == nreq - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of req found
// when scanning upward from start and wrapping modulo NREQ.
module rr_pick #(
  parameter int  NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic            found,
  output logic [IW-1:0]   index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(start) + k) % NREQ]) begin
        found = 1'b1;
        index = IW'((int'(start) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NREQ requesters,
// with bounded bursts and full-flag stall. Macro ARB_STATS_EN adds counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  DATASIZE  = 8,
  parameter int  NREQ      = 4,
  parameter int  MAX_BURST = 4,
  localparam int IW        = $clog2(NREQ)
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DATASIZE-1:0]      wdata,
  output logic [IW-1:0]            wsrc,
  input  logic                     stat_clr,
  output logic [NREQ*STAT_W-1:0]   stat_cnt
);

  arb_state_e      state, state_d;
  logic [IW-1:0]   gnt, gnt_d;
  logic [IW-1:0]   rr_last, rr_last_d;
  logic [3:0]      beat_cnt, beat_cnt_d;

  logic            release_any;
  logic [NREQ-1:0] pick_req;
  logic [IW-1:0]   pick_start;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;

  // Handshake outputs and picker inputs; the picker result is consumed
  // separately below so the picker is not part of a same-block loop.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch.
    req_ready   = '0;
    winc        = 1'b0;
    wdata       = '0;
    wsrc        = '0;
    release_any = 1'b0;
    pick_req    = req_valid;
    pick_start  = IW'(rr_next(int'(rr_last), NREQ));
    if (state == BUSY) begin
      req_ready[gnt] = !wfull;
      winc           = req_valid[gnt] & !wfull;
      wsrc           = gnt;
      if (winc) wdata = req_data[int'(gnt)*DATASIZE +: DATASIZE];
      release_any = (winc && beat_cnt == 4'(MAX_BURST - 1)) || !req_valid[gnt];
      pick_start  = IW'(rr_next(int'(gnt), NREQ));
      // A requester that dropped valid must not win its own re-grant.
      if (!req_valid[gnt]) pick_req[gnt] = 1'b0;
    end
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .index (pick_idx)
  );

  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    beat_cnt_d = beat_cnt;
    rr_last_d  = rr_last;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_d    = BUSY;
          gnt_d      = pick_idx;
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        if (release_any) begin
          rr_last_d = gnt;
          if (pick_found) begin
            gnt_d      = pick_idx;
            beat_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (winc) begin
          beat_cnt_d = beat_cnt + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state    <= IDLE;
      gnt      <= '0;
      beat_cnt <= '0;
      rr_last  <= IW'(NREQ - 1);
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      beat_cnt <= beat_cnt_d;
      rr_last  <= rr_last_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NREQ];

  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (stat_clr)
          stat_q[i] <= '0;
        else if (winc && gnt == IW'(i) && stat_q[i] != '1)
          stat_q[i] <= stat_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) stat_cnt[i*STAT_W +: STAT_W] = stat_q[i];
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_cnt        = '0;
`endif

endmodule
